// File: rtl/pwm_cfg_pkg.sv
// Shared constants and types for the SPI configuration block of the PWM core:
// the register map, reset values, CTRL bit positions and the frame layout.
package pwm_cfg_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int CTRL_W = 4;

  // Register map
  localparam logic [ADDR_W-1:0] ADDR_PERIOD    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_PRESCALER = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_CTRL      = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CH0_DUTY  = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_CH1_DUTY  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_CH2_DUTY  = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_STATUS    = 3'd6;
  localparam logic [ADDR_W-1:0] ADDR_ID        = 3'd7;

  // Reset values
  localparam logic [DATA_W-1:0] DEF_PERIOD_RST = 8'hFF;
  localparam logic [DATA_W-1:0] PRESCALER_RST  = 8'h00;
  localparam logic [CTRL_W-1:0] CTRL_RST       = 4'h0;
  localparam logic [DATA_W-1:0] DUTY_RST       = 8'h00;

  // CTRL bit positions
  localparam int CTRL_TIMER_EN = 0;
  localparam int CTRL_CH0_EN   = 1;
  localparam int CTRL_CH1_EN   = 2;
  localparam int CTRL_CH2_EN   = 3;

  // Frame layout: 8 command bits followed by 8 data bits
  localparam int FRAME_BITS = 16;
  localparam int CMD_BITS   = 8;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0] CMD_LAST_BIT   = CNT_W'(CMD_BITS - 1);
  localparam logic [CNT_W-1:0] FRAME_LAST_BIT = CNT_W'(FRAME_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_DONE
  } frame_state_t;

endpackage

// File: rtl/spi_slave_shifter.sv
// SPI mode-0 slave front end: synchronises the SPI pins into clk, tracks the
// 16-bit frame and hands command, write data and read-load strobes to the
// register bank.
module spi_slave_shifter
  import pwm_cfg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  output logic              cmd_valid,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              cmd_write,
  output logic              wr_valid,
  output logic [DATA_W-1:0] wr_data,
  output logic              rd_load,
  input  logic [DATA_W-1:0] rd_data
);

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync;
  logic                   sclk_d, cs_d;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  frame_state_t           state, state_next;
  logic [CNT_W-1:0]       bit_cnt;
  logic [DATA_W-2:0]      rx_shift;
  logic [DATA_W-1:0]      rx_byte_next;
  logic [DATA_W-1:0]      tx_shift;
  logic                   tx_active;
  logic                   write_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_fall   = ~cs_s & cs_d;
  assign cs_rise   = cs_s & ~cs_d;

  // Byte including the bit arriving on this rising edge
  assign rx_byte_next = {rx_shift, mosi_s};
  assign cmd_addr     = rx_byte_next[ADDR_W-1:0];
  assign cmd_write    = rx_byte_next[DATA_W-1];

  assign miso_oe = ~cs_s;
  assign miso    = tx_active & tx_shift[DATA_W-1] & (state == ST_DATA);

  // Pin synchronisers and edge-detect history; cs_n idles high out of reset
  always_ff @(posedge clk) begin
    // NOTE: every clocked assignment is non-blocking so all flops sample
    // pre-edge values, which is what makes the chains real shift registers.
    if (!reset) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
    end
  end

  // Frame state register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic and command/read strobes
  always_comb begin
    // NOTE: defaults first so every path assigns every output; otherwise a
    // missed branch would infer a latch.
    state_next = state;
    cmd_valid  = 1'b0;
    rd_load    = 1'b0;
    case (state)
      ST_IDLE: if (cs_fall) state_next = ST_CMD;
      ST_CMD: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else if (sclk_rise && bit_cnt == CMD_LAST_BIT) begin
          state_next = ST_DATA;
          cmd_valid  = 1'b1;
          rd_load    = ~cmd_write;
        end
      end
      ST_DATA: begin
        if (cs_rise)                                         state_next = ST_IDLE;
        else if (sclk_rise && bit_cnt == FRAME_LAST_BIT)     state_next = ST_DONE;
      end
      ST_DONE: if (cs_rise) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Bit counter, RX/TX shift registers and the registered write strobe
  always_ff @(posedge clk) begin
    if (!reset) begin
      bit_cnt   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      tx_active <= 1'b0;
      write_q   <= 1'b0;
      wr_valid  <= 1'b0;
      wr_data   <= '0;
    end else begin
      wr_valid <= 1'b0;
      if (state == ST_IDLE && cs_fall) begin
        bit_cnt   <= '0;
        tx_active <= 1'b0;
      end
      if ((state == ST_CMD || state == ST_DATA) && sclk_rise && !cs_rise) begin
        bit_cnt  <= bit_cnt + 1'b1;
        rx_shift <= rx_byte_next[DATA_W-2:0];
      end
      if (cmd_valid) begin
        write_q   <= cmd_write;
        tx_active <= 1'b0;
      end
      if (rd_load) tx_shift <= rd_data;
      // First falling edge of the data phase exposes the MSB; later ones shift
      if (state == ST_DATA && sclk_fall && !write_q) begin
        if (tx_active) tx_shift  <= {tx_shift[DATA_W-2:0], 1'b0};
        else           tx_active <= 1'b1;
      end
      if (state == ST_DATA && state_next == ST_DONE) begin
        wr_valid <= write_q;
        wr_data  <= rx_byte_next;
      end
    end
  end

endmodule

// File: rtl/pwm_spi_cfg.sv
// SPI-programmable configuration register bank for the PWM core. PERIOD and
// duty cycles are double-buffered and move to the core on a period boundary
// (or continuously while the timer is stopped); status bits are sticky.
module pwm_spi_cfg
  import pwm_cfg_pkg::*;
#(
  parameter int                SYNC_STAGES = 2,
  parameter logic [DATA_W-1:0] ID_VALUE    = 8'hA5,
  parameter logic [DATA_W-1:0] PERIOD_RST  = DEF_PERIOD_RST
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              period_complete,
  input  logic              timer_overflow,
  output logic [DATA_W-1:0] period,
  output logic [DATA_W-1:0] prescaler,
  output logic              timer_enable,
  output logic              ch0_enable,
  output logic              ch1_enable,
  output logic              ch2_enable,
  output logic [DATA_W-1:0] ch0_duty_cycle,
  output logic [DATA_W-1:0] ch1_duty_cycle,
  output logic [DATA_W-1:0] ch2_duty_cycle
);

  logic              cmd_valid, cmd_write, wr_valid, rd_load;
  logic [ADDR_W-1:0] cmd_addr, wr_addr;
  logic [DATA_W-1:0] wr_data, rd_data;

  logic [DATA_W-1:0] period_shadow, ch0_shadow, ch1_shadow, ch2_shadow;
  logic [CTRL_W-1:0] ctrl;
  logic [1:0]        sticky, pulses, status_now;
  logic              transfer, status_clear;

  spi_slave_shifter #(.SYNC_STAGES(SYNC_STAGES)) u_shifter (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .cmd_valid (cmd_valid),
    .cmd_addr  (cmd_addr),
    .cmd_write (cmd_write),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .rd_load   (rd_load),
    .rd_data   (rd_data)
  );

  assign timer_enable = ctrl[CTRL_TIMER_EN];
  assign ch0_enable   = ctrl[CTRL_CH0_EN];
  assign ch1_enable   = ctrl[CTRL_CH1_EN];
  assign ch2_enable   = ctrl[CTRL_CH2_EN];

  assign transfer     = period_complete | ~ctrl[CTRL_TIMER_EN];
  assign pulses       = {timer_overflow, period_complete};
  assign status_now   = sticky | pulses;
  assign status_clear = rd_load && cmd_addr == ADDR_STATUS;

  // Remember the target of a write command until its data byte arrives
  always_ff @(posedge clk) begin
    if (!reset)                     wr_addr <= '0;
    else if (cmd_valid && cmd_write) wr_addr <= cmd_addr;
  end

  // Write commit into shadows and immediate registers; RO addresses ignored
  always_ff @(posedge clk) begin
    if (!reset) begin
      period_shadow <= PERIOD_RST;
      ch0_shadow    <= DUTY_RST;
      ch1_shadow    <= DUTY_RST;
      ch2_shadow    <= DUTY_RST;
      prescaler     <= PRESCALER_RST;
      ctrl          <= CTRL_RST;
    end else if (wr_valid) begin
      case (wr_addr)
        ADDR_PERIOD:    period_shadow <= wr_data;
        ADDR_PRESCALER: prescaler     <= wr_data;
        ADDR_CTRL:      ctrl          <= wr_data[CTRL_W-1:0];
        ADDR_CH0_DUTY:  ch0_shadow    <= wr_data;
        ADDR_CH1_DUTY:  ch1_shadow    <= wr_data;
        ADDR_CH2_DUTY:  ch2_shadow    <= wr_data;
        default: ;
      endcase
    end
  end

  // Shadow-to-active transfer; a same-clk write is seen one transfer later
  always_ff @(posedge clk) begin
    if (!reset) begin
      period         <= PERIOD_RST;
      ch0_duty_cycle <= DUTY_RST;
      ch1_duty_cycle <= DUTY_RST;
      ch2_duty_cycle <= DUTY_RST;
    end else if (transfer) begin
      period         <= period_shadow;
      ch0_duty_cycle <= ch0_shadow;
      ch1_duty_cycle <= ch1_shadow;
      ch2_duty_cycle <= ch2_shadow;
    end
  end

  // Sticky status; a pulse coincident with the read-clear survives it
  always_ff @(posedge clk) begin
    if (!reset)            sticky <= '0;
    else if (status_clear) sticky <= pulses;
    else                   sticky <= status_now;
  end

  // Read mux, sampled into the TX register on rd_load
  always_comb begin
    rd_data = '0;
    case (cmd_addr)
      ADDR_PERIOD:    rd_data = period_shadow;
      ADDR_PRESCALER: rd_data = prescaler;
      ADDR_CTRL:      rd_data = {{(DATA_W-CTRL_W){1'b0}}, ctrl};
      ADDR_CH0_DUTY:  rd_data = ch0_shadow;
      ADDR_CH1_DUTY:  rd_data = ch1_shadow;
      ADDR_CH2_DUTY:  rd_data = ch2_shadow;
      ADDR_STATUS:    rd_data = {{(DATA_W-2){1'b0}}, status_now};
      ADDR_ID:        rd_data = ID_VALUE;
      default:        rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_pwm_spi_cfg.sv
// Directed bench for pwm_spi_cfg: bit-banged SPI mode-0 frames with
// hand-computed expected register and MISO values.
module tb_pwm_spi_cfg;

  logic       clk = 1'b0;
  logic       reset, sclk, cs_n, mosi, period_complete, timer_overflow;
  logic       miso, miso_oe, timer_enable, ch0_enable, ch1_enable, ch2_enable;
  logic [7:0] period, prescaler, ch0_duty_cycle, ch1_duty_cycle, ch2_duty_cycle;

  int checks = 0;
  int errors = 0;

  pwm_spi_cfg dut (
    .clk             (clk),
    .reset           (reset),
    .sclk            (sclk),
    .cs_n            (cs_n),
    .mosi            (mosi),
    .miso            (miso),
    .miso_oe         (miso_oe),
    .period_complete (period_complete),
    .timer_overflow  (timer_overflow),
    .period          (period),
    .prescaler       (prescaler),
    .timer_enable    (timer_enable),
    .ch0_enable      (ch0_enable),
    .ch1_enable      (ch1_enable),
    .ch2_enable      (ch2_enable),
    .ch0_duty_cycle  (ch0_duty_cycle),
    .ch1_duty_cycle  (ch1_duty_cycle),
    .ch2_duty_cycle  (ch2_duty_cycle)
  );

  always #5 clk = ~clk;

  // One SPI frame, sclk period = 8 clk. pc_mode 1 pulses period_complete in
  // the clk where the command is decoded (rd_load), pc_mode 2 in the clk
  // where the write commits. hold_cs leaves cs_n low after the last bit.
  task automatic spi_frame(input logic [15:0] word, input int nbits, input int pc_mode,
                           input bit hold_cs, output logic [7:0] rx, output logic oe_seen);
    rx      = '0;
    oe_seen = 1'b0;
    @(negedge clk);
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      mosi = word[15-i];
      repeat (4) @(negedge clk);
      if (i == 0) oe_seen = miso_oe;
      if (i >= 8) rx[15-i] = miso;
      sclk = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        period_complete = (pc_mode == 1 && i == 7 && k == 2) ||
                          (pc_mode == 2 && i == 15 && k == 3);
      end
      sclk = 1'b0;
    end
    if (!hold_cs) begin
      repeat (4) @(negedge clk);
      cs_n = 1'b1;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [7:0] data, input int pc_mode,
                           output logic [7:0] rx);
    logic oe;
    spi_frame({5'b10000, addr, data}, 16, pc_mode, 1'b0, rx, oe);
  endtask

  task automatic read_reg(input logic [7:0] cmd, input int pc_mode, output logic [7:0] data);
    logic oe;
    spi_frame({cmd, 8'h00}, 16, pc_mode, 1'b0, data, oe);
  endtask

  task automatic pulse_pc();
    @(negedge clk) period_complete = 1'b1;
    @(negedge clk) period_complete = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_to();
    @(negedge clk) timer_overflow = 1'b1;
    @(negedge clk) timer_overflow = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (period !== 8'hFF) begin
      errors++; $display("FAIL reset_period got %h exp ff", period);
    end
    checks++;
    if (prescaler !== 8'h00) begin
      errors++; $display("FAIL reset_prescaler got %h exp 00", prescaler);
    end
    checks++;
    if ({ch2_enable, ch1_enable, ch0_enable, timer_enable} !== 4'h0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 0000",
                         {ch2_enable, ch1_enable, ch0_enable, timer_enable});
    end
    checks++;
    if ({ch0_duty_cycle, ch1_duty_cycle, ch2_duty_cycle} !== 24'h0) begin
      errors++; $display("FAIL reset_duty got %h exp 000000",
                         {ch0_duty_cycle, ch1_duty_cycle, ch2_duty_cycle});
    end
    checks++;
    if ({miso, miso_oe} !== 2'b00) begin
      errors++; $display("FAIL reset_miso got %b exp 00", {miso, miso_oe});
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_status();
    logic [7:0] got;
    pulse_to();
    read_reg(8'h06, 0, got);
    checks++;
    if (got !== 8'h02) begin errors++; $display("FAIL status_overflow got %h exp 02", got); end
    read_reg(8'h06, 0, got);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL status_cleared got %h exp 00", got); end
    read_reg(8'h06, 1, got);
    checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL status_same_clk got %h exp 01", got); end
    read_reg(8'h06, 0, got);
    checks++;
    if (got !== 8'h01) begin errors++; $display("FAIL status_kept got %h exp 01", got); end
  endtask

  task automatic test_immediate();
    logic [7:0] got;
    write_reg(3'd3, 8'h40, 0, got);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL write_miso_idle got %h exp 00", got); end
    checks++;
    if (ch0_duty_cycle !== 8'h40) begin
      errors++; $display("FAIL ch0_duty_te0 got %h exp 40", ch0_duty_cycle);
    end
    write_reg(3'd1, 8'h12, 0, got);
    checks++;
    if (prescaler !== 8'h12) begin errors++; $display("FAIL prescaler got %h exp 12", prescaler); end
    read_reg(8'h03, 0, got);
    checks++;
    if (got !== 8'h40) begin errors++; $display("FAIL ch0_readback got %h exp 40", got); end
  endtask

  task automatic test_shadow();
    logic [7:0] got;
    write_reg(3'd2, 8'hF3, 0, got);
    checks++;
    if ({ch2_enable, ch1_enable, ch0_enable, timer_enable} !== 4'b0011) begin
      errors++; $display("FAIL ctrl_outputs got %b exp 0011",
                         {ch2_enable, ch1_enable, ch0_enable, timer_enable});
    end
    read_reg(8'h02, 0, got);
    checks++;
    if (got !== 8'h03) begin errors++; $display("FAIL ctrl_readback got %h exp 03", got); end
    write_reg(3'd4, 8'h80, 0, got);
    checks++;
    if (ch1_duty_cycle !== 8'h00) begin
      errors++; $display("FAIL ch1_held got %h exp 00", ch1_duty_cycle);
    end
    read_reg(8'h04, 0, got);
    checks++;
    if (got !== 8'h80) begin errors++; $display("FAIL ch1_shadow got %h exp 80", got); end
    pulse_pc();
    checks++;
    if (ch1_duty_cycle !== 8'h80) begin
      errors++; $display("FAIL ch1_transfer got %h exp 80", ch1_duty_cycle);
    end
    write_reg(3'd4, 8'h22, 2, got);
    checks++;
    if (ch1_duty_cycle !== 8'h80) begin
      errors++; $display("FAIL ch1_commit_collision got %h exp 80", ch1_duty_cycle);
    end
    pulse_pc();
    checks++;
    if (ch1_duty_cycle !== 8'h22) begin
      errors++; $display("FAIL ch1_next_period got %h exp 22", ch1_duty_cycle);
    end
  endtask

  task automatic test_abort();
    logic [7:0] got;
    logic       oe;
    spi_frame(16'h8010, 12, 0, 1'b0, got, oe);
    checks++;
    if (period !== 8'hFF) begin errors++; $display("FAIL abort_period got %h exp ff", period); end
    read_reg(8'h00, 0, got);
    checks++;
    if (got !== 8'hFF) begin errors++; $display("FAIL abort_shadow got %h exp ff", got); end
    write_reg(3'd0, 8'h10, 0, got);
    read_reg(8'h00, 0, got);
    checks++;
    if (got !== 8'h10) begin errors++; $display("FAIL period_shadow got %h exp 10", got); end
    checks++;
    if (period !== 8'hFF) begin errors++; $display("FAIL period_held got %h exp ff", period); end
    pulse_pc();
    checks++;
    if (period !== 8'h10) begin errors++; $display("FAIL period_transfer got %h exp 10", period); end
  endtask

  task automatic test_read_id();
    logic [7:0] got;
    logic       oe;
    spi_frame(16'h0700, 16, 0, 1'b0, got, oe);
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL id_read got %h exp a5", got); end
    checks++;
    if (oe !== 1'b1) begin errors++; $display("FAIL oe_in_frame got %b exp 1", oe); end
    checks++;
    if (miso_oe !== 1'b0) begin errors++; $display("FAIL oe_after_frame got %b exp 0", miso_oe); end
    write_reg(3'd7, 8'h00, 0, got);
    read_reg(8'h7F, 0, got);
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL id_ignored_bits got %h exp a5", got); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] got;
    logic       oe;
    spi_frame(16'h8155, 10, 0, 1'b1, got, oe);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({period, prescaler, ch0_duty_cycle, ch1_duty_cycle, ch2_duty_cycle} !== 40'hFF_00_00_00_00) begin
      errors++; $display("FAIL midreset_regs got %h exp ff00000000",
                         {period, prescaler, ch0_duty_cycle, ch1_duty_cycle, ch2_duty_cycle});
    end
    checks++;
    if ({timer_enable, ch0_enable, ch1_enable, ch2_enable, miso, miso_oe} !== 6'b0) begin
      errors++; $display("FAIL midreset_bits got %b exp 000000",
                         {timer_enable, ch0_enable, ch1_enable, ch2_enable, miso, miso_oe});
    end
    cs_n = 1'b1;
    sclk = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    write_reg(3'd1, 8'h5A, 0, got);
    checks++;
    if (prescaler !== 8'h5A) begin errors++; $display("FAIL post_reset_write got %h exp 5a", prescaler); end
    read_reg(8'h07, 0, got);
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL post_reset_id got %h exp a5", got); end
    read_reg(8'h02, 0, got);
    checks++;
    if (got !== 8'h00) begin errors++; $display("FAIL post_reset_ctrl got %h exp 00", got); end
  endtask

  initial begin
    reset           = 1'b0;
    sclk            = 1'b0;
    cs_n            = 1'b1;
    mosi            = 1'b0;
    period_complete = 1'b0;
    timer_overflow  = 1'b0;
    test_reset();
    test_status();
    test_immediate();
    test_shadow();
    test_abort();
    test_read_id();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
